// File: rtl/fpro_bus_pkg.sv
// Shared FPro bus definitions: bus widths, address field widths and the
// burst-master FSM state type.
package fpro_bus_pkg;

  localparam int FPRO_ADDR_W = 21;
  localparam int FPRO_DATA_W = 32;
  localparam int SLOT_W      = 6;
  localparam int REG_W       = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_STB,
    RD_RSP,
    WR_WAIT,
    WR_STB,
    WR_RSP
  } state_t;

  // Debug view of the master's control state.
  typedef struct packed {
    state_t state;
    logic   wr;
    logic   fixed;
  } dbg_t;

  // Next beat address; incrementing addresses wrap modulo 2^FPRO_ADDR_W.
  function automatic logic [FPRO_ADDR_W-1:0] next_addr(
    input logic [FPRO_ADDR_W-1:0] addr,
    input logic                   fixed
  );
    return fixed ? addr : addr + FPRO_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fpro_bus_master.sv
// Burst master for the FPro MMIO bus: turns one command into 1..2^LEN_W
// single-cycle read or write strobes and returns responses on a stream.
module fpro_bus_master
  import fpro_bus_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  // Every stream below (cmd, wd, rsp) transfers exactly on a rising edge where
  // its valid and ready are both high; valid never waits for ready.
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [FPRO_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   cmd_fixed,
  input  logic                   wd_valid,
  output logic                   wd_ready,
  input  logic [FPRO_DATA_W-1:0] wd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [FPRO_DATA_W-1:0] rsp_data,
  output logic                   rsp_last,
  output logic                   busy,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [FPRO_ADDR_W-1:0] mmio_addr,
  output logic [FPRO_DATA_W-1:0] mmio_wr_data,
  input  logic [FPRO_DATA_W-1:0] mmio_rd_data,
  output dbg_t                   dbg
);

  state_t                 state;
  logic [FPRO_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]       cnt;
  logic                   fixed_q;
  logic                   wr_q;

  assign mmio_addr = addr_q;

  assign dbg.state = state;
  assign dbg.wr    = wr_q;
  assign dbg.fixed = fixed_q;

  // All outputs are registers updated together with the state, so each one
  // is set on the transition into the state where it must be asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      wd_ready     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_last     <= 1'b0;
      rsp_data     <= '0;
      mmio_cs      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_wr_data <= '0;
      addr_q       <= '0;
      cnt          <= '0;
      fixed_q      <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            cnt       <= cmd_len;
            fixed_q   <= cmd_fixed;
            wr_q      <= cmd_wr;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_wr) begin
              state    <= WR_WAIT;
              wd_ready <= 1'b1;
            end else begin
              state   <= RD_STB;
              mmio_cs <= 1'b1;
              mmio_rd <= 1'b1;
            end
          end
        end

        RD_STB: begin
          mmio_cs   <= 1'b0;
          mmio_rd   <= 1'b0;
          rsp_data  <= mmio_rd_data;
          rsp_valid <= 1'b1;
          rsp_last  <= (cnt == '0);
          if (cnt != '0) cnt <= cnt - LEN_W'(1);
          addr_q    <= next_addr(addr_q, fixed_q);
          state     <= RD_RSP;
        end

        RD_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (rsp_last) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state   <= RD_STB;
              mmio_cs <= 1'b1;
              mmio_rd <= 1'b1;
            end
          end
        end

        WR_WAIT: begin
          if (wd_valid) begin
            wd_ready     <= 1'b0;
            mmio_wr_data <= wd_data;
            mmio_cs      <= 1'b1;
            mmio_wr      <= 1'b1;
            state        <= WR_STB;
          end
        end

        WR_STB: begin
          mmio_cs <= 1'b0;
          mmio_wr <= 1'b0;
          addr_q  <= next_addr(addr_q, fixed_q);
          if (cnt == '0) begin
            state     <= WR_RSP;
            rsp_valid <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_data  <= '0;
          end else begin
            cnt      <= cnt - LEN_W'(1);
            state    <= WR_WAIT;
            wd_ready <= 1'b1;
          end
        end

        WR_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
